sdram_stream_checker: RTL and testbench

//  Consumes the 16-bit word stream read back from SDRAM (SDRAM_Q / SDRAM_Q_ASSERTED) in parallel with FIFO_FROM_SDRAM.
//  The upstream stream generator emits an incrementing 32-bit count, split low half first; this block rebuilds the

---
 rtl/sdram_stream_chk_pkg.sv | 28 ++
 rtl/sdram_stream_checker_sat_counter.sv | 29 ++
 rtl/sdram_stream_checker.sv | 184 ++++++++++++++++++
 tb/tb_sdram_stream_checker.sv | 306 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sdram_stream_chk_pkg.sv
// Package: sdram_stream_chk_pkg
// Shared definitions for the SDRAM read-back stream checker and the matching
// stream generator bench: checker state encoding, half-word ordering of the
// 32-bit count on the 16-bit bus, and default widths.
package sdram_stream_chk_pkg;

    // Checker state encoding, in sequence order.
    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_SEED_LO  = 3'd1,
        ST_SEED_HI  = 3'd2,
        ST_CHECK_LO = 3'd3,
        ST_CHECK_HI = 3'd4
    } chk_state_t;

    // The generator emits the low 16 bits of each count first.
    localparam bit HALF_ORDER_LO_FIRST = 1'b1;

    localparam int DATA_W         = 16;
    localparam int CNT_W          = 32;
    localparam int DEF_ERR_CNT_W  = 16;
    localparam int DEF_WORD_CNT_W = 32;
    localparam int DEF_LOCK_WORDS = 4;

    // LOCK_WORDS is limited to 1..255, so an 8-bit run counter suffices.
    localparam int GOOD_RUN_W     = 8;

endpackage

// File: rtl/sdram_stream_checker_sat_counter.sv
// Module: sat_counter
// Up-counter that sticks at all-ones instead of wrapping.
// Ports:
//   clk    in   clock
//   n_rst  in   async active-low reset (q -> 0)
//   inc    in   count up by one this cycle (ignored once saturated)
//   clr    in   synchronous clear, wins over inc
//   q      out  WIDTH-bit count
module sat_counter #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             n_rst,
    input  logic             inc,
    input  logic             clr,
    output logic [WIDTH-1:0] q
);

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            q <= '0;
        end else if (clr) begin
            q <= '0;
        end else if (inc && (q != {WIDTH{1'b1}})) begin
            q <= q + WIDTH'(1);
        end
    end

endmodule

// File: rtl/sdram_stream_checker.sv
// Module: sdram_stream_checker
// Checks the 16-bit word stream read back from SDRAM against the incrementing
// 32-bit count the upstream generator wrote (low half first). The first two
// valid words seed the expected value; every following word is compared, and
// lock state, a saturating error count and a first-error snapshot are kept
// for debug readout. All outputs are registered.
//
// Build option: define CHK_RESYNC_EN to let a mismatched 32-bit word reseed the
// expected count from the received pair, so a single skipped/inserted count
// costs one error burst. Undefined, the expected count free-runs.
//
// Ports:
//   clk             in   clock (CLK_48 domain)
//   n_rst           in   async active-low reset
//   en              in   check enable; low -> IDLE, counters hold
//   clr             in   sync clear of counters/flags, restarts seeding
//   s16             in   stream word
//   s16_vld         in   s16 valid this cycle
//   locked          out  LOCK_WORDS consecutive good 32-bit words seen
//   err             out  sticky mismatch flag
//   err_cnt         out  mismatched words, saturating
//   word_cnt        out  words compared, wrapping
//   first_err_idx   out  word_cnt at the first mismatch
//   first_err_data  out  received word at the first mismatch
module sdram_stream_checker
    import sdram_stream_chk_pkg::*;
#(
    parameter int ERR_CNT_W  = DEF_ERR_CNT_W,
    parameter int WORD_CNT_W = DEF_WORD_CNT_W,
    parameter int LOCK_WORDS = DEF_LOCK_WORDS
) (
    input  logic                  clk,
    input  logic                  n_rst,
    input  logic                  en,
    input  logic                  clr,
    input  logic [DATA_W-1:0]     s16,
    input  logic                  s16_vld,
    output logic                  locked,
    output logic                  err,
    output logic [ERR_CNT_W-1:0]  err_cnt,
    output logic [WORD_CNT_W-1:0] word_cnt,
    output logic [WORD_CNT_W-1:0] first_err_idx,
    output logic [DATA_W-1:0]     first_err_data
);

    // locked is set on the pair that brings good_run up to LOCK_WORDS,
    // i.e. when the pre-increment value equals LOCK_WORDS-1.
    localparam logic [GOOD_RUN_W-1:0] LOCK_M1 = GOOD_RUN_W'(LOCK_WORDS - 1);

    chk_state_t state, state_nxt;

    logic [CNT_W-1:0]      exp_q;
    logic                  lo_ok;      // low half of the current pair matched
    logic [GOOD_RUN_W-1:0] good_run;
`ifdef CHK_RESYNC_EN
    logic [DATA_W-1:0]     rx_lo;      // low word received in CHECK_LO
`endif

    logic              upd;
    logic              chk_lo;
    logic              chk_hi;
    logic [DATA_W-1:0] exp_half;
    logic              mism;
    logic              pair_good;

    // ------------------------------------------------------------------
    // State machine
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        if (clr) begin
            state_nxt = en ? ST_SEED_LO : ST_IDLE;
        end else if (!en) begin
            state_nxt = ST_IDLE;
        end else begin
            case (state)
                ST_IDLE:     state_nxt = ST_SEED_LO;
                ST_SEED_LO:  if (s16_vld) state_nxt = ST_SEED_HI;
                ST_SEED_HI:  if (s16_vld) state_nxt = ST_CHECK_LO;
                ST_CHECK_LO: if (s16_vld) state_nxt = ST_CHECK_HI;
                ST_CHECK_HI: if (s16_vld) state_nxt = ST_CHECK_LO;
                default:     state_nxt = ST_IDLE;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Compare
    // ------------------------------------------------------------------
    // clr drops the word on the bus, so it also masks every update.
    assign upd       = en && !clr && s16_vld;
    assign chk_lo    = upd && (state == ST_CHECK_LO);
    assign chk_hi    = upd && (state == ST_CHECK_HI);
    assign exp_half  = chk_hi ? exp_q[CNT_W-1:DATA_W] : exp_q[DATA_W-1:0];
    assign mism      = (chk_lo || chk_hi) && (s16 != exp_half);
    assign pair_good = chk_hi && !mism && lo_ok;

    sat_counter #(.WIDTH(ERR_CNT_W)) u_err_cnt (
        .clk   (clk),
        .n_rst (n_rst),
        .inc   (mism),
        .clr   (clr),
        .q     (err_cnt)
    );

    // Any mismatch restarts the run of good pairs.
    sat_counter #(.WIDTH(GOOD_RUN_W)) u_good_run (
        .clk   (clk),
        .n_rst (n_rst),
        .inc   (pair_good),
        .clr   (clr || mism),
        .q     (good_run)
    );

    // ------------------------------------------------------------------
    // Expected value, counters and capture registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            exp_q          <= '0;
            lo_ok          <= 1'b0;
            word_cnt       <= '0;
            err            <= 1'b0;
            first_err_idx  <= '0;
            first_err_data <= '0;
            locked         <= 1'b0;
`ifdef CHK_RESYNC_EN
            rx_lo          <= '0;
`endif
        end else if (clr) begin
            lo_ok          <= 1'b0;
            word_cnt       <= '0;
            err            <= 1'b0;
            first_err_idx  <= '0;
            first_err_data <= '0;
            locked         <= 1'b0;
        end else if (upd) begin
            case (state)
                ST_SEED_LO: exp_q[DATA_W-1:0] <= s16;
                ST_SEED_HI: exp_q <= {s16, exp_q[DATA_W-1:0]} + CNT_W'(1);
                ST_CHECK_LO: begin
                    lo_ok <= !mism;
`ifdef CHK_RESYNC_EN
                    rx_lo <= s16;
`endif
                end
                ST_CHECK_HI: begin
`ifdef CHK_RESYNC_EN
                    // Re-anchor on what actually arrived so a skipped count
                    // does not keep every later pair in error.
                    exp_q <= mism ? ({s16, rx_lo} + CNT_W'(1)) : (exp_q + CNT_W'(1));
`else
                    exp_q <= exp_q + CNT_W'(1);
`endif
                end
                default: ;
            endcase

            if (chk_lo || chk_hi) begin
                word_cnt <= word_cnt + WORD_CNT_W'(1);
            end

            if (mism) begin
                err    <= 1'b1;
                locked <= 1'b0;
                if (!err) begin
                    first_err_idx  <= word_cnt;
                    first_err_data <= s16;
                end
            end else if (pair_good && (good_run >= LOCK_M1)) begin
                locked <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_sdram_stream_checker.sv
// Testbench for sdram_stream_checker: reference model + scoreboard compared
// every cycle, a vector table for the count wrap, and directed sequences for
// lock, first-error capture, skip, clear/reset/enable and saturation.
module tb_sdram_stream_checker;

    localparam int LOCK = 4;
    localparam int S_IDLE = 0, S_SLO = 1, S_SHI = 2, S_CLO = 3, S_CHI = 4;

    logic        clk = 1'b0;
    logic        n_rst = 1'b0;
    logic        en = 1'b0;
    logic        clr = 1'b0;
    logic [15:0] s16 = '0;
    logic        s16_vld = 1'b0;
    logic        locked;
    logic        err;
    logic [15:0] err_cnt;
    logic [31:0] word_cnt;
    logic [31:0] first_err_idx;
    logic [15:0] first_err_data;

    sdram_stream_checker #(
        .ERR_CNT_W  (16),
        .WORD_CNT_W (32),
        .LOCK_WORDS (LOCK)
    ) dut (
        .clk            (clk),
        .n_rst          (n_rst),
        .en             (en),
        .clr            (clr),
        .s16            (s16),
        .s16_vld        (s16_vld),
        .locked         (locked),
        .err            (err),
        .err_cnt        (err_cnt),
        .word_cnt       (word_cnt),
        .first_err_idx  (first_err_idx),
        .first_err_data (first_err_data)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    typedef struct {
        logic        locked;
        logic        err;
        logic [15:0] ec;
        logic [31:0] wc;
        logic [31:0] fidx;
        logic [15:0] fdata;
    } obs_t;
    obs_t sbq[$];

    typedef struct {
        logic        en;
        logic        clr;
        logic        vld;
        logic [15:0] s16;
        logic [31:0] x_wc;
        logic [15:0] x_ec;
        logic        x_lk;
    } vec_t;
    vec_t tv[14];

    // Reference model state
    int          m_state;
    int          m_good;
    logic [31:0] m_exp, m_word, m_fidx;
    logic [15:0] m_ec, m_fdata;
    logic        m_err, m_locked, m_lo_ok;
`ifdef CHK_RESYNC_EN
    logic [15:0] m_rxlo;
`endif

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            if (failures <= 20)
                $display("FAIL %s actual=%h required=%h t=%0t", nm, act, req, $time);
        end
    endtask

    task automatic m_reset();
        m_state = S_IDLE; m_good = 0; m_exp = '0; m_word = '0; m_fidx = '0;
        m_ec = '0; m_fdata = '0; m_err = 0; m_locked = 0; m_lo_ok = 0;
    endtask

    task automatic m_cmp(input logic [15:0] w, input logic [15:0] e, output bit bad);
        bad = (w != e);
        if (bad) begin
            if (!m_err) begin
                m_fidx  = m_word;
                m_fdata = w;
            end
            m_err    = 1;
            m_good   = 0;
            m_locked = 0;
            if (m_ec != 16'hFFFF) m_ec = m_ec + 16'd1;
        end
        m_word = m_word + 32'd1;
    endtask

    task automatic m_step(input logic e, input logic c, input logic v, input logic [15:0] d);
        bit bad;
        if (c) begin
            m_word = '0; m_err = 0; m_ec = '0; m_fidx = '0; m_fdata = '0;
            m_locked = 0; m_good = 0; m_lo_ok = 0;
            m_state = e ? S_SLO : S_IDLE;
        end else if (!e) begin
            m_state = S_IDLE;
        end else if (m_state == S_IDLE) begin
            m_state = S_SLO;
        end else if (v) begin
            case (m_state)
                S_SLO: begin m_exp[15:0] = d; m_state = S_SHI; end
                S_SHI: begin m_exp = {d, m_exp[15:0]} + 32'd1; m_state = S_CLO; end
                S_CLO: begin
                    m_cmp(d, m_exp[15:0], bad);
                    m_lo_ok = !bad;
`ifdef CHK_RESYNC_EN
                    m_rxlo = d;
`endif
                    m_state = S_CHI;
                end
                default: begin
                    m_cmp(d, m_exp[31:16], bad);
                    if (!bad && m_lo_ok) begin
                        m_good++;
                        if (m_good >= LOCK) m_locked = 1;
                    end
`ifdef CHK_RESYNC_EN
                    m_exp = bad ? ({d, m_rxlo} + 32'd1) : (m_exp + 32'd1);
`else
                    m_exp = m_exp + 32'd1;
`endif
                    m_state = S_CLO;
                end
            endcase
        end
    endtask

    // One clock: drive, push model prediction, sample after the edge, compare.
    task automatic cycle(input logic e, input logic c, input logic v, input logic [15:0] d);
        obs_t x;
        en = e; clr = c; s16_vld = v; s16 = d;
        m_step(e, c, v, d);
        sbq.push_back('{m_locked, m_err, m_ec, m_word, m_fidx, m_fdata});
        @(posedge clk);
        #1;
        x = sbq.pop_front();
        chk("sb_locked", locked, x.locked);
        chk("sb_err", err, x.err);
        chk("sb_err_cnt", err_cnt, x.ec);
        chk("sb_word_cnt", word_cnt, x.wc);
        chk("sb_first_err_idx", first_err_idx, x.fidx);
        chk("sb_first_err_data", first_err_data, x.fdata);
    endtask

    task automatic send_cnt_x(input logic [31:0] c, input logic [15:0] xlo, input logic [15:0] xhi);
        cycle(1, 0, 1, c[15:0] ^ xlo);
        cycle(1, 0, 1, c[31:16] ^ xhi);
    endtask

    task automatic send_cnt(input logic [31:0] c);
        send_cnt_x(c, 16'h0, 16'h0);
    endtask

    task automatic chk_zero(input string nm);
        chk({nm, "_locked"}, locked, 0);
        chk({nm, "_err"}, err, 0);
        chk({nm, "_err_cnt"}, err_cnt, 0);
        chk({nm, "_word_cnt"}, word_cnt, 0);
        chk({nm, "_fidx"}, first_err_idx, 0);
        chk({nm, "_fdata"}, first_err_data, 0);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // Wrap table: seed FFFF_FFFD, expected starts at FFFF_FFFE.
        tv[0]  = '{1, 1, 0, 16'h0000, 0, 0, 0};
        tv[1]  = '{1, 0, 1, 16'hFFFD, 0, 0, 0};
        tv[2]  = '{1, 0, 1, 16'hFFFF, 0, 0, 0};
        tv[3]  = '{1, 0, 1, 16'hFFFE, 1, 0, 0};
        tv[4]  = '{1, 0, 0, 16'h1234, 1, 0, 0};
        tv[5]  = '{1, 0, 1, 16'hFFFF, 2, 0, 0};
        tv[6]  = '{1, 0, 1, 16'hFFFF, 3, 0, 0};
        tv[7]  = '{1, 0, 1, 16'hFFFF, 4, 0, 0};
        tv[8]  = '{1, 0, 1, 16'h0000, 5, 0, 0};
        tv[9]  = '{1, 0, 1, 16'h0000, 6, 0, 0};
        tv[10] = '{1, 0, 1, 16'h0001, 7, 0, 0};
        tv[11] = '{1, 0, 1, 16'h0000, 8, 0, 1};
        tv[12] = '{1, 0, 1, 16'h0002, 9, 0, 1};
        tv[13] = '{1, 0, 1, 16'h0000, 10, 0, 1};

        // Reset state
        m_reset();
        #2;
        chk_zero("reset");
        @(posedge clk); #1;
        n_rst = 1'b1;

        // 1: seed 0x10, 64 words, lock on 4th good pair
        cycle(1, 0, 0, 16'h0);
        send_cnt(32'h10);
        for (int i = 1; i < 32; i++) begin
            send_cnt(32'h10 + 32'(i));
            if (i == 3) chk("t1_locked_pair3", locked, 0);
            if (i == 4) chk("t1_locked_pair4", locked, 1);
        end
        chk("t1_err_cnt", err_cnt, 0);
        chk("t1_locked", locked, 1);
        chk("t1_word_cnt", word_cnt, 62);

        // 2: corrupt checked word 9 (high half of count 0x15)
        cycle(1, 1, 1, 16'hABCD);
        send_cnt(32'h10);
        for (int i = 1; i <= 4; i++) send_cnt(32'h10 + 32'(i));
        chk("t2_locked_before", locked, 1);
        send_cnt_x(32'h15, 16'h0, 16'h1);
        chk("t2_err", err, 1);
        chk("t2_err_cnt", err_cnt, 1);
        chk("t2_fidx", first_err_idx, 9);
        chk("t2_fdata", first_err_data, 16'h0001);
        chk("t2_locked_drop", locked, 0);
        for (int i = 6; i <= 8; i++) send_cnt(32'h10 + 32'(i));
        chk("t2_locked_3pairs", locked, 0);
        send_cnt(32'h19);
        chk("t2_locked_relock", locked, 1);
        chk("t2_err_cnt_end", err_cnt, 1);

        // 3: wrap through 0xFFFF_FFFF, table driven
        for (int i = 0; i < 14; i++) begin
            cycle(tv[i].en, tv[i].clr, tv[i].vld, tv[i].s16);
            chk("t3_word_cnt", word_cnt, tv[i].x_wc);
            chk("t3_err_cnt", err_cnt, tv[i].x_ec);
            chk("t3_locked", locked, tv[i].x_lk);
        end

        // 4: skip count 0x1_FFFF after locking
        cycle(1, 1, 0, 16'h0);
        send_cnt(32'h0001_FFFA);
        for (int i = 1; i <= 4; i++) send_cnt(32'h0001_FFFA + 32'(i));
        chk("t4_locked_pre", locked, 1);
        for (int k = 0; k < 6; k++) send_cnt(32'h0002_0000 + 32'(k));
        chk("t4_word_cnt", word_cnt, 20);
`ifdef CHK_RESYNC_EN
        chk("t4_err_cnt", err_cnt, 2);
        chk("t4_locked", locked, 1);
`else
        chk("t4_err_cnt", err_cnt, 7);
        chk("t4_locked", locked, 0);
`endif

        // 6: clr mid-CHECK_HI, reset mid-stream, en toggled mid-seed
        cycle(1, 1, 0, 16'h0);
        send_cnt(32'h100);
        send_cnt_x(32'h101, 16'h8000, 16'h0);
        cycle(1, 0, 1, 16'h0102);
        chk("t6_err_before_clr", err, 1);
        cycle(1, 1, 1, 16'h0000);
        chk_zero("t6_clr");
        send_cnt(32'h700);
        send_cnt(32'h701);
        chk("t6_clr_err", err, 0);
        chk("t6_clr_word_cnt", word_cnt, 2);
        cycle(1, 0, 1, 16'h0702);
        n_rst = 1'b0;
        #1;
        m_reset();
        chk_zero("t6_rst");
        @(posedge clk); #1;
        chk_zero("t6_rst_held");
        n_rst = 1'b1;
        cycle(1, 0, 0, 16'h0);
        cycle(1, 0, 1, 16'h0500);
        cycle(0, 0, 1, 16'h0000);
        cycle(1, 0, 1, 16'hDEAD);
        send_cnt(32'h600);
        send_cnt(32'h601);
        send_cnt(32'h602);
        chk("t6_en_err", err, 0);
        chk("t6_en_word_cnt", word_cnt, 4);

        // 5: saturate err_cnt with 66000 mismatched words
        cycle(1, 1, 0, 16'h0);
        send_cnt(32'h0);
        for (int i = 1; i <= 33000; i++) send_cnt(~32'(i));
        chk("t5_err_cnt_sat", err_cnt, 16'hFFFF);
        chk("t5_word_cnt", word_cnt, 66000);
        chk("t5_err", err, 1);
        chk("t5_fidx", first_err_idx, 0);
        chk("t5_fdata", first_err_data, 16'hFFFE);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
